// File: rtl/imem_refill_responder.sv
// Instruction-cache line refill responder: reads a line critical-word-first from a
// fixed-latency memory and returns it through a credit-protected skid FIFO.
module imem_refill_responder #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LATENCY    = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              abort,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDRESS_WIDTH-1:0]          req_addr,
  output logic                              mem_en,
  output logic [ADDRESS_WIDTH-1:0]          mem_addr,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [$clog2(WORDS_PER_LINE)-1:0] rsp_idx,
  output logic                              rsp_last,
  output logic                              busy
);
  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = ADDRESS_WIDTH - IDX_W - 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CRED_W = $clog2(FIFO_DEPTH + MEM_LATENCY + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [LINE_W-1:0]     r_lineAddr;
  logic [IDX_W-1:0]      r_start;
  logic [IDX_W:0]        r_issued;
  logic [MEM_LATENCY-1:0] r_tagValid;
  logic [MEM_LATENCY-1:0] r_tagLast;
  logic [IDX_W-1:0]      r_tagIdx [MEM_LATENCY];
  logic [DATA_WIDTH-1:0] r_fifoData [FIFO_DEPTH];
  logic [IDX_W-1:0]      r_fifoIdx [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifoLast;
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W:0]        r_count;

  logic                  w_accept;
  logic                  w_issueLast;
  logic                  w_credit;
  logic                  w_push;
  logic                  w_pop;
  logic [IDX_W-1:0]      w_issueIdx;
  logic [CRED_W-1:0]     w_inflight;
  logic                  w_unusedAddrBits;

  // The byte offset inside a word never affects which words are fetched.
  assign w_unusedAddrBits = ^req_addr[1:0];

  assign req_ready = (r_state == IDLE) && !abort;
  assign w_accept  = req_valid && req_ready;
  assign busy      = (r_state != IDLE);

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < MEM_LATENCY; k++) begin
      w_inflight = w_inflight + CRED_W'(r_tagValid[k]);
    end
  end

  // Every outstanding read owns a FIFO slot, so the FIFO can never overflow.
  assign w_credit    = (w_inflight + CRED_W'(r_count)) < CRED_W'(FIFO_DEPTH);
  assign mem_en      = (r_state == ISSUE) && w_credit;
  assign w_issueIdx  = r_start + r_issued[IDX_W-1:0];
  assign w_issueLast = (r_issued == (IDX_W+1)'(WORDS_PER_LINE - 1));
  assign mem_addr    = mem_en ? {r_lineAddr, w_issueIdx, 2'b00} : '0;

  assign rsp_valid = (r_count != '0);
  assign rsp_data  = rsp_valid ? r_fifoData[r_rdPtr] : '0;
  assign rsp_idx   = rsp_valid ? r_fifoIdx[r_rdPtr]  : '0;
  assign rsp_last  = rsp_valid ? r_fifoLast[r_rdPtr] : 1'b0;
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_push    = r_tagValid[MEM_LATENCY-1];

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = ISSUE;
      ISSUE:   if (mem_en && w_issueLast) w_nextState = DRAIN;
      DRAIN:   if (w_pop && rsp_last) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (abort) w_nextState = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_lineAddr <= '0;
      r_start    <= '0;
      r_issued   <= '0;
    end else begin
      r_state <= w_nextState;
      if (abort) begin
        r_issued <= '0;
      end else if (w_accept) begin
        r_lineAddr <= req_addr[ADDRESS_WIDTH-1:IDX_W+2];
        r_start    <= req_addr[IDX_W+1:2];
        r_issued   <= '0;
      end else if (mem_en) begin
        r_issued <= r_issued + (IDX_W+1)'(1);
      end
    end
  end

  // Only the valid bits are cleared by abort; stale payload is then never pushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tagValid <= '0;
    end else if (abort) begin
      r_tagValid <= '0;
    end else begin
      r_tagValid[0] <= mem_en;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        r_tagValid[k] <= r_tagValid[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_tagIdx[0]  <= w_issueIdx;
    r_tagLast[0] <= w_issueLast;
    for (int k = 1; k < MEM_LATENCY; k++) begin
      r_tagIdx[k]  <= r_tagIdx[k-1];
      r_tagLast[k] <= r_tagLast[k-1];
    end
    if (w_push) begin
      r_fifoData[r_wrPtr] <= mem_rdata;
      r_fifoIdx[r_wrPtr]  <= r_tagIdx[MEM_LATENCY-1];
      r_fifoLast[r_wrPtr] <= r_tagLast[MEM_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (abort) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
